// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with optional two-entry skid, stall freeze and bubble insertion.
// Latency 1 cycle; in_ready_o is registered-state based when SKID_EN=1, stall/bubble block input.
module pipe_skid_reg #(
    parameter int                DATA_W     = 148,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
    parameter int                SKID_EN    = 1
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_bubble_o,
    output logic [1:0]        occ_o
);

    // Encoding equals the entry count so occ_o is a straight copy of the state.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              bub_q, bub_d;
    logic              in_block;
    logic              push;
    logic              pop;

    always_comb begin
        if (SKID_EN != 0) begin
            in_block = (state_q == FULL);
        end else begin
            in_block = (state_q != EMPTY) & ~out_ready_i;
        end
    end

    // rstn_i gates ready so nothing is offered as accepted while reset is held.
    assign in_ready_o   = rstn_i & ~in_block & ~stall_i & ~bubble_i;
    assign out_valid_o  = (state_q != EMPTY) & ~stall_i;
    assign push         = in_valid_i & in_ready_o;
    assign pop          = out_valid_o & out_ready_i;
    assign out_data_o   = m_q;
    assign out_bubble_o = bub_q;
    assign occ_o        = state_q;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        bub_d   = bub_q;
        if (!stall_i) begin
            if (bubble_i) begin
                m_d     = BUBBLE_VAL;
                bub_d   = 1'b1;
                state_d = ONE;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (push) begin
                            m_d     = in_data_i;
                            bub_d   = 1'b0;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            m_d   = in_data_i;
                            bub_d = 1'b0;
                        end else if (push && (SKID_EN != 0)) begin
                            s_d     = in_data_i;
                            state_d = FULL;
                        end else if (pop) begin
                            state_d = EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            m_d     = s_q;
                            bub_d   = 1'b0;
                            state_d = ONE;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= EMPTY;
            m_q     <= '0;
            s_q     <= '0;
            bub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            s_q     <= s_d;
            bub_q   <= bub_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int              DW = 16;
    localparam logic [DW-1:0]   BV = 16'hBBBB;

    logic          clk = 1'b0;
    logic          rstn;
    logic          stall, bubble, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          irdy1, ovld1, obub1;
    logic [DW-1:0] odat1;
    logic [1:0]    occ1;
    logic          irdy0, ovld0, obub0;
    logic [DW-1:0] odat0;
    logic [1:0]    occ0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(.DATA_W(DW), .BUBBLE_VAL(BV), .SKID_EN(1)) dut (
        .clk_i(clk), .rstn_i(rstn), .stall_i(stall), .bubble_i(bubble),
        .in_valid_i(in_valid), .in_ready_o(irdy1), .in_data_i(in_data),
        .out_valid_o(ovld1), .out_ready_i(out_ready), .out_data_o(odat1),
        .out_bubble_o(obub1), .occ_o(occ1)
    );

    pipe_skid_reg #(.DATA_W(DW), .BUBBLE_VAL(BV), .SKID_EN(0)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .stall_i(stall), .bubble_i(bubble),
        .in_valid_i(in_valid), .in_ready_o(irdy0), .in_data_i(in_data),
        .out_valid_o(ovld0), .out_ready_i(out_ready), .out_data_o(odat0),
        .out_bubble_o(obub0), .occ_o(occ0)
    );

    typedef struct {
        logic          st, bu, iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          e_irdy, e_ovld;
        logic [DW-1:0] e_odat;
        logic [1:0]    e_occ;
        logic          e_bub;
    } vec_t;

    vec_t vt [$];
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic bu, input logic iv,
                         input logic [DW-1:0] id, input logic ordy);
        stall = st; bubble = bu; in_valid = iv; in_data = id; out_ready = ordy;
    endtask

    initial begin
        rstn = 1'b0;
        drive(0, 0, 0, '0, 0);

        //            st bu iv id        ordy irdy ovld odat      occ  bub
        vt.push_back('{0, 0, 1, 16'h1234, 0,  1,   0,   16'h0000, 2'd1, 0});
        vt.push_back('{0, 0, 1, 16'h5678, 0,  1,   1,   16'h1234, 2'd2, 0});
        vt.push_back('{0, 0, 1, 16'h9999, 0,  0,   1,   16'h1234, 2'd2, 0});
        vt.push_back('{0, 0, 0, 16'h0000, 1,  0,   1,   16'h1234, 2'd1, 0});
        vt.push_back('{0, 0, 0, 16'h0000, 1,  1,   1,   16'h5678, 2'd0, 0});
        vt.push_back('{0, 0, 0, 16'h0000, 0,  1,   0,   16'h0000, 2'd0, 0});
        vt.push_back('{0, 0, 1, 16'h1234, 0,  1,   0,   16'h0000, 2'd1, 0});
        vt.push_back('{0, 0, 1, 16'h5678, 0,  1,   1,   16'h1234, 2'd2, 0});
        vt.push_back('{1, 0, 1, 16'hAAAA, 1,  0,   0,   16'h0000, 2'd2, 0});
        vt.push_back('{1, 0, 1, 16'hAAAA, 1,  0,   0,   16'h0000, 2'd2, 0});
        vt.push_back('{1, 0, 1, 16'hAAAA, 1,  0,   0,   16'h0000, 2'd2, 0});
        vt.push_back('{0, 0, 0, 16'h0000, 1,  0,   1,   16'h1234, 2'd1, 0});
        vt.push_back('{0, 0, 0, 16'h0000, 1,  1,   1,   16'h5678, 2'd0, 0});
        vt.push_back('{0, 0, 1, 16'h1234, 0,  1,   0,   16'h0000, 2'd1, 0});
        vt.push_back('{0, 0, 1, 16'h5678, 0,  1,   1,   16'h1234, 2'd2, 0});
        vt.push_back('{1, 1, 0, 16'h0000, 1,  0,   0,   16'h0000, 2'd2, 0});
        vt.push_back('{0, 1, 1, 16'hAAAA, 0,  0,   1,   16'h1234, 2'd1, 1});
        vt.push_back('{0, 0, 0, 16'h0000, 0,  1,   1,   16'hBBBB, 2'd1, 1});
        vt.push_back('{0, 0, 1, 16'h4321, 1,  1,   1,   16'hBBBB, 2'd1, 0});
        vt.push_back('{0, 0, 0, 16'h0000, 1,  1,   1,   16'h4321, 2'd0, 0});

        #2;
        chk("rst_occ",   occ1,  0);
        chk("rst_irdy",  irdy1, 0);
        chk("rst_ovld",  ovld1, 0);
        chk("rst_bub",   obub1, 0);
        chk("rst_odat",  odat1, 0);
        chk("rst_occ0",  occ0,  0);

        @(negedge clk);
        rstn = 1'b1;

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].st, vt[i].bu, vt[i].iv, vt[i].id, vt[i].ordy);
            #2;
            chk($sformatf("v%0d_irdy", i), irdy1, vt[i].e_irdy);
            chk($sformatf("v%0d_ovld", i), ovld1, vt[i].e_ovld);
            if (vt[i].e_ovld) chk($sformatf("v%0d_odat", i), odat1, vt[i].e_odat);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_occ", i), occ1, vt[i].e_occ);
            chk($sformatf("v%0d_bub", i), obub1, vt[i].e_bub);
        end

        // Streaming: 8 items with both sides always ready, one item per cycle.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k < 8) begin
                drive(0, 0, 1, 16'hC000 + DW'(k), 1);
                exp_q.push_back(16'hC000 + DW'(k));
            end else begin
                drive(0, 0, 0, '0, 1);
            end
            #2;
            if (k < 8) chk($sformatf("s%0d_irdy", k), irdy1, 1);
            if (ovld1 && out_ready) begin
                if (exp_q.size() > 0) chk($sformatf("s%0d_odat", k), odat1, exp_q.pop_front());
                else chk($sformatf("s%0d_extra", k), 1, 0);
            end
            @(posedge clk);
            #1;
            chk($sformatf("s%0d_occ", k), occ1, (k < 8) ? 1 : 0);
        end
        chk("s_all_popped", exp_q.size(), 0);

        // Single-entry variant: fresh reset, then fill and check ready follows out_ready_i.
        @(negedge clk);
        rstn = 1'b0;
        drive(0, 0, 0, '0, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        drive(0, 0, 1, 16'h1111, 1);
        #2;
        chk("n0_irdy", irdy0, 1);
        @(posedge clk);
        #1;
        chk("n0_occ", occ0, 1);
        @(negedge clk);
        drive(0, 0, 1, 16'h2222, 1);
        #2;
        chk("n1_irdy_one", irdy0, 1);
        chk("n1_odat", odat0, 16'h1111);
        @(posedge clk);
        #1;
        chk("n1_occ", occ0, 1);
        chk("n1_bub", obub0, 0);
        @(negedge clk);
        drive(0, 0, 1, 16'h3333, 0);
        #2;
        chk("n2_irdy_blk", irdy0, 0);
        chk("n2_odat", odat0, 16'h2222);
        @(posedge clk);
        #1;
        chk("n2_occ", occ0, 1);

        // Asynchronous reset between edges, both instances occupied.
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_occ0", occ0, 0);
        chk("ar_irdy0", irdy0, 0);
        chk("ar_ovld0", ovld0, 0);
        chk("ar_occ1", occ1, 0);
        chk("ar_irdy1", irdy1, 0);
        @(negedge clk);
        rstn = 1'b1;
        drive(0, 0, 1, 16'h7777, 0);
        #2;
        chk("rel_irdy0", irdy0, 1);
        chk("rel_irdy1", irdy1, 1);
        @(posedge clk);
        #1;
        chk("rel_occ0", occ0, 1);
        chk("rel_odat0", odat0, 16'h7777);
        chk("rel_occ1", occ1, 1);
        chk("rel_odat1", odat1, 16'h7777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
